// File: rtl/vme_bus_pkg.sv
// vme_bus_pkg: state, DSACK and strobe-mask encodings shared by the VME strobe sequencer.
package vme_bus_pkg;

    typedef enum logic [2:0] {IDLE, SETUP, STROBE, ACK, ERROR, RELEASE} vme_state_t;

    localparam logic [1:0] DSACK_NONE = 2'b11;
    localparam logic [1:0] DSACK_16 = 2'b01;
    localparam logic [1:0] SIZ_BYTE = 2'b01;

    // Masks are {ds1, ds0}; a set bit means that strobe is asserted during the transfer.
    localparam logic [1:0] STROBE_DS0 = 2'b01;
    localparam logic [1:0] STROBE_DS1 = 2'b10;
    localparam logic [1:0] STROBE_BOTH = 2'b11;

    function automatic logic [1:0] strobe_mask(input logic [1:0] size, input logic a0);
        return size != SIZ_BYTE ? STROBE_BOTH : (a0 ? STROBE_DS0 : STROBE_DS1);
    endfunction

endpackage

// File: rtl/vme_strobe_sequencer_input_synchronizer.sv
// input_synchronizer: 2-flop synchronizer for active-low asynchronous inputs; flops reset to 1 (negated).
module input_synchronizer #(
    parameter int WIDTH = 1
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] raw,
    output logic [WIDTH-1:0] synced
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            meta <= '1;
            synced <= '1;
        end else begin
            meta <= raw;
            synced <= meta;
        end
    end

endmodule

// File: rtl/vme_strobe_sequencer.sv
// vme_strobe_sequencer: runs one VME data strobe cycle per 68030 bus cycle and returns DSACK or bus error.
// Define VME_STROBE_TIMEOUT_EN to build the local STROBE timeout; otherwise the system bus timer is relied on.
module vme_strobe_sequencer
    import vme_bus_pkg::*;
#(
    parameter int SETUP_CYCLES = 2,
    parameter int TIMEOUT_CYCLES = 255,
    parameter int RELEASE_CYCLES = 1
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       cpu_address_strobe,
    input  logic       cpu_data_strobe,
    input  logic       cpu_rw,
    input  logic [1:0] cpu_size,
    input  logic       cpu_a0,
    input  logic       vme_selected,
    input  logic       vme_dtack_n,
    input  logic       vme_berr_n,
    inout  wire        data_strobe_0,
    inout  wire        data_strobe_1,
    output logic       vme_write_n,
    output logic [1:0] cpu_dsack_n,
    output logic       cpu_berr_n,
    output logic       busy
);

    logic as_n, ds_n, dtack_n, berr_n;
    vme_state_t state, state_next;
    logic [7:0] phase_count, phase_next;
    logic [1:0] mask, mask_next;
    logic write_next, timeout_hit, strobe_on;
    logic [1:0] strobe_value;

    input_synchronizer #(.WIDTH(4)) u_sync (
        .clock  (clock),
        .reset_n(reset_n),
        .raw    ({cpu_address_strobe, cpu_data_strobe, vme_dtack_n, vme_berr_n}),
        .synced ({as_n, ds_n, dtack_n, berr_n})
    );

`ifdef VME_STROBE_TIMEOUT_EN
    logic [7:0] timeout_count;

    // Held at zero outside STROBE, so every SETUP entry starts a fresh count.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) timeout_count <= '0;
        else timeout_count <= state == STROBE ? timeout_count + 8'd1 : '0;
    end

    assign timeout_hit = timeout_count == 8'(TIMEOUT_CYCLES - 1);
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT_CYCLES;
    assign timeout_hit = 1'b0;
`endif

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            phase_count <= '0;
            mask <= '0;
            vme_write_n <= 1'b1;
        end else begin
            state <= state_next;
            phase_count <= phase_next;
            mask <= mask_next;
            vme_write_n <= write_next;
        end
    end

    always_comb begin
        state_next = state;
        mask_next = mask;
        write_next = vme_write_n;
        case (state)
            IDLE:
                if (!as_n && !ds_n && vme_selected && dtack_n) begin
                    state_next = SETUP;
                    mask_next = strobe_mask(cpu_size, cpu_a0);
                    write_next = cpu_rw;
                end
            SETUP:
                state_next = as_n ? RELEASE : phase_count == 8'(SETUP_CYCLES - 1) ? STROBE : SETUP;
            STROBE:
                state_next = as_n ? RELEASE : (!berr_n || timeout_hit) ? ERROR : !dtack_n ? ACK : STROBE;
            ACK, ERROR:
                state_next = as_n ? RELEASE : state;
            RELEASE:
                state_next = phase_count == 8'(RELEASE_CYCLES - 1) ? IDLE : RELEASE;
            default:
                state_next = IDLE;
        endcase
        phase_next = state_next != state ? '0 : phase_count + 8'd1;
    end

    assign strobe_on = state == STROBE || state == ACK || state == ERROR;
    assign strobe_value = strobe_on ? ~mask : 2'b11;
    assign data_strobe_0 = state != IDLE ? strobe_value[0] : 1'bz;
    assign data_strobe_1 = state != IDLE ? strobe_value[1] : 1'bz;
    assign cpu_dsack_n = state == ACK ? DSACK_16 : DSACK_NONE;
    assign cpu_berr_n = state != ERROR;
    assign busy = state != IDLE;

endmodule
